// File: rtl/jtag_pkg.sv
// Shared TAP definitions: controller state encodings, instruction codes and
// the IR capture pattern used by the TAP core and its FSM.
package jtag_pkg;

  typedef enum logic [3:0] {
    ST_TLR    = 4'hF,
    ST_RTI    = 4'hC,
    ST_SEL_DR = 4'h7,
    ST_CAP_DR = 4'h6,
    ST_SH_DR  = 4'h2,
    ST_EX1_DR = 4'h1,
    ST_PAU_DR = 4'h3,
    ST_EX2_DR = 4'h0,
    ST_UPD_DR = 4'h5,
    ST_SEL_IR = 4'h4,
    ST_CAP_IR = 4'hE,
    ST_SH_IR  = 4'hA,
    ST_EX1_IR = 4'h9,
    ST_PAU_IR = 4'hB,
    ST_EX2_IR = 4'h8,
    ST_UPD_IR = 4'hD
  } tap_state_e;

  // Which data register the current instruction places between TDI and TDO
  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_e;

  // Instruction constants at the maximum IR width; the core truncates them
  localparam logic [7:0] IR_BYPASS    = 8'hFF;
  localparam logic [7:0] IR_IDCODE    = 8'h01;
  localparam logic [7:0] IR_USER_BASE = 8'h02;
  localparam logic [7:0] IR_CAPTURE   = 8'h01;

endpackage

// File: rtl/jtag_tap_core_if.sv
// Pin bundle of the TAP core: serial scan pins, user-DR hooks and status.
interface jtag_tap_core_if #(
  parameter int unsigned IR_W    = 4,
  parameter int unsigned NUM_UDR = 2
);

  logic               TMS;
  logic               TDI;
  logic               TDO;
  logic               TDO_EN;
  logic [NUM_UDR-1:0] UDR_TDO;
  logic [NUM_UDR-1:0] UDR_SEL;
  logic               CAPTUREDR;
  logic               SHIFTDR;
  logic               UPDATEDR;
  logic [IR_W-1:0]    IR_OUT;
  logic               TLR;

  // Board / test side driving the TAP
  modport master (
    output TMS, TDI, UDR_TDO,
    input  TDO, TDO_EN, UDR_SEL, CAPTUREDR, SHIFTDR, UPDATEDR, IR_OUT, TLR
  );

  // TAP core side
  modport slave (
    input  TMS, TDI, UDR_TDO,
    output TDO, TDO_EN, UDR_SEL, CAPTUREDR, SHIFTDR, UPDATEDR, IR_OUT, TLR
  );

endinterface

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: 16-state machine stepped by TMS on posedge TCK.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_e state
);

  tap_state_e state_q, state_d;

  // State register with synchronous TRST
  always_ff @(posedge TCK) begin
    if (TRST) state_q <= ST_TLR;
    else      state_q <= state_d;
  end

  // Standard TMS-driven transitions
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:    state_d = TMS ? ST_TLR    : ST_RTI;
      ST_RTI:    state_d = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: state_d = TMS ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: state_d = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  state_d = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: state_d = TMS ? ST_UPD_DR : ST_PAU_DR;
      ST_PAU_DR: state_d = TMS ? ST_EX2_DR : ST_PAU_DR;
      ST_EX2_DR: state_d = TMS ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: state_d = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: state_d = TMS ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: state_d = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  state_d = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: state_d = TMS ? ST_UPD_IR : ST_PAU_IR;
      ST_PAU_IR: state_d = TMS ? ST_EX2_IR : ST_PAU_IR;
      ST_EX2_IR: state_d = TMS ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: state_d = TMS ? ST_SEL_DR : ST_RTI;
      default:   state_d = ST_TLR;
    endcase
  end

  // Present the registered state
  always_comb begin
    state = state_q;
  end

endmodule

// File: rtl/jtag_tap_core.sv
// JTAG TAP core: instruction register, BYPASS/IDCODE data registers, user-DR
// routing and the negedge-launched TDO path around the jtag_tap_fsm controller.
module jtag_tap_core
  import jtag_pkg::*;
#(
  parameter int unsigned IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
  parameter int unsigned NUM_UDR    = 2
) (
  input  logic TCK,
  input  logic TRST,
  jtag_tap_core_if.slave jif
);

  localparam logic [IR_W-1:0] IR_BYP = IR_BYPASS[IR_W-1:0];
  localparam logic [IR_W-1:0] IR_ID  = IR_IDCODE[IR_W-1:0];
  localparam logic [IR_W-1:0] IR_CAP = IR_CAPTURE[IR_W-1:0];
  localparam logic [31:0]     ID_VAL = IDCODE_VAL | 32'h0000_0001;

  tap_state_e state;

  logic [IR_W-1:0]    ir_sr_q, ir_sr_d;
  logic [IR_W-1:0]    ir_q, ir_d;
  logic [IR_W-1:0]    ir_eff;
  logic               dr_byp_q, dr_byp_d;
  logic [31:0]        dr_id_q, dr_id_d;
  logic               tdo_q, tdo_d;
  logic               tdo_en_q, tdo_en_d;
  dr_sel_e            dr_sel;
  logic [NUM_UDR-1:0] udr_sel;

  jtag_tap_fsm u_fsm (
    .TCK   (TCK),
    .TRST  (TRST),
    .TMS   (jif.TMS),
    .state (state)
  );

  // Instruction decode; while in TLR the instruction already reads as IDCODE
  // so it takes effect the moment TLR is entered, before ir_q is rewritten.
  always_comb begin
    ir_eff  = (state == ST_TLR) ? IR_ID : ir_q;
    dr_sel  = DR_BYPASS;
    udr_sel = '0;
    if (ir_eff == IR_BYP) begin
      dr_sel = DR_BYPASS;
    end else if (ir_eff == IR_ID) begin
      dr_sel = DR_IDCODE;
    end else begin
      for (int unsigned k = 0; k < NUM_UDR; k++) begin
        if (32'(ir_eff) == 32'(IR_USER_BASE) + k) begin
          udr_sel[k] = 1'b1;
          dr_sel     = DR_USER;
        end
      end
    end
  end

  // IR shift register and latched instruction next-state
  always_comb begin
    ir_sr_d = ir_sr_q;
    ir_d    = ir_q;
    case (state)
      ST_TLR:    ir_d    = IR_ID;
      ST_CAP_IR: ir_sr_d = IR_CAP;
      ST_SH_IR:  ir_sr_d = {jif.TDI, ir_sr_q[IR_W-1:1]};
      ST_UPD_IR: ir_d    = ir_sr_q;
      default:   ;
    endcase
  end

  // BYPASS / IDCODE capture and shift; pause states fall through and hold
  always_comb begin
    dr_byp_d = dr_byp_q;
    dr_id_d  = dr_id_q;
    if (state == ST_CAP_DR) begin
      case (dr_sel)
        DR_BYPASS: dr_byp_d = 1'b0;
        DR_IDCODE: dr_id_d  = ID_VAL;
        default:   ;
      endcase
    end else if (state == ST_SH_DR) begin
      case (dr_sel)
        DR_BYPASS: dr_byp_d = jif.TDI;
        DR_IDCODE: dr_id_d  = {jif.TDI, dr_id_q[31:1]};
        default:   ;
      endcase
    end
  end

  // IR/DR registers with synchronous TRST
  always_ff @(posedge TCK) begin
    if (TRST) begin
      ir_sr_q  <= IR_CAP;
      ir_q     <= IR_ID;
      dr_byp_q <= 1'b0;
      dr_id_q  <= '0;
    end else begin
      ir_sr_q  <= ir_sr_d;
      ir_q     <= ir_d;
      dr_byp_q <= dr_byp_d;
      dr_id_q  <= dr_id_d;
    end
  end

  // Serial output source: only the two shift states drive data
  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    if (state == ST_SH_IR) begin
      tdo_d    = ir_sr_q[0];
      tdo_en_d = 1'b1;
    end else if (state == ST_SH_DR) begin
      tdo_en_d = 1'b1;
      case (dr_sel)
        DR_BYPASS: tdo_d = dr_byp_q;
        DR_IDCODE: tdo_d = dr_id_q[0];
        DR_USER:   tdo_d = |(udr_sel & jif.UDR_TDO);
        default:   tdo_d = 1'b0;
      endcase
    end
  end

  // TDO launch on the falling edge, half a cycle ahead of the capturing edge
  always_ff @(negedge TCK) begin
    if (TRST) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  // Output pins
  always_comb begin
    jif.TDO       = tdo_q;
    jif.TDO_EN    = tdo_en_q;
    jif.UDR_SEL   = udr_sel;
    jif.CAPTUREDR = (state == ST_CAP_DR) && (|udr_sel);
    jif.SHIFTDR   = (state == ST_SH_DR)  && (|udr_sel);
    jif.UPDATEDR  = (state == ST_UPD_DR) && (|udr_sel);
    jif.IR_OUT    = ir_eff;
    jif.TLR       = (state == ST_TLR);
  end

endmodule

// File: tb/tb_jtag_tap_core.sv
// Self-checking bench for jtag_tap_core: directed TAP walks plus randomized
// instruction/data scans checked against a behavioural scan-chain model.
module tb_jtag_tap_core;

  localparam int unsigned IR_W    = 4;
  localparam int unsigned NUM_UDR = 2;
  localparam logic [31:0] IDC     = 32'h1000_0001;

  logic TCK  = 1'b0;
  logic TRST = 1'b0;

  int total = 0;
  int bad   = 0;

  jtag_tap_core_if #(.IR_W(IR_W), .NUM_UDR(NUM_UDR)) jif ();

  jtag_tap_core #(
    .IR_W       (IR_W),
    .IDCODE_VAL (IDC),
    .NUM_UDR    (NUM_UDR)
  ) dut (
    .TCK  (TCK),
    .TRST (TRST),
    .jif  (jif)
  );

  always #5 TCK = ~TCK;

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] mask_n(input int unsigned n);
    if (n >= 64) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction

  // 0 = bypass, 1 = idcode, 2+k = user k
  function automatic int kind_of(input logic [IR_W-1:0] c);
    if (c == {IR_W{1'b1}}) return 0;
    if (int'(c) == 1) return 1;
    if (int'(c) >= 2 && int'(c) < 2 + int'(NUM_UDR)) return int'(c);
    return 0;
  endfunction

  function automatic logic [NUM_UDR-1:0] sel_of(input logic [IR_W-1:0] c);
    int k;
    k = kind_of(c);
    if (k < 2) return '0;
    return NUM_UDR'(1) << (k - 2);
  endfunction

  // Bits seen on TDO while shifting n bits of tdi through the selected DR
  function automatic logic [63:0] dr_out(input int k, input int unsigned n,
                                          input logic [63:0] tdi,
                                          input logic [NUM_UDR-1:0] udr);
    if (k == 0) return (tdi << 1) & mask_n(n);
    if (k == 1) return ((tdi << 32) | 64'(IDC)) & mask_n(n);
    return udr[k-2] ? mask_n(n) : 64'd0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic tms, input logic tdi);
    jif.TMS = tms;
    jif.TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #1;
  endtask

  task automatic go_rti();
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic pulse_trst();
    TRST = 1'b1;
    step(1'b0, 1'b0);
    TRST = 1'b0;
  endtask

  // RTI -> scan n bits -> Update -> RTI; returns TDO bits and TDO_EN errors
  task automatic scan(input bit is_ir, input int unsigned n, input logic [63:0] tdi,
                      output logic [63:0] tdo, output int unsigned en_err);
    tdo    = '0;
    en_err = 0;
    step(1'b1, 1'b0);
    if (is_ir) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int unsigned i = 0; i < n; i++) begin
      tdo[i] = jif.TDO;
      if (jif.TDO_EN !== 1'b1) en_err++;
      step(i == n - 1, tdi[i]);
    end
    if (jif.TDO_EN !== 1'b0 || jif.TDO !== 1'b0) en_err++;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [IR_W-1:0] v);
    logic [63:0] t;
    int unsigned e;
    scan(1'b1, IR_W, 64'(v), t, e);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int trial = 0; trial < 2; trial++) begin
      if (trial == 1) begin
        go_rti();
        load_ir(4'h3);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      end
      pulse_trst();
      total++; if (jif.TLR !== 1'b1) begin bad++; $display("FAIL reset_tlr: got %b expected 1", jif.TLR); end
      total++; if (jif.IR_OUT !== 4'h1) begin bad++; $display("FAIL reset_ir: got %h expected 1", jif.IR_OUT); end
      total++; if (jif.TDO !== 1'b0 || jif.TDO_EN !== 1'b0) begin bad++; $display("FAIL reset_tdo: got tdo=%b en=%b expected 0/0", jif.TDO, jif.TDO_EN); end
      total++; if (jif.UDR_SEL !== 2'b00) begin bad++; $display("FAIL reset_udr_sel: got %b expected 00", jif.UDR_SEL); end
      total++; if ({jif.CAPTUREDR, jif.SHIFTDR, jif.UPDATEDR} !== 3'b000) begin bad++; $display("FAIL reset_strobes: got %b expected 000", {jif.CAPTUREDR, jif.SHIFTDR, jif.UPDATEDR}); end
    end
  endtask

  task automatic test_trst_abort();
    go_rti();
    load_ir(4'h3);
    total++; if (jif.IR_OUT !== 4'h3) begin bad++; $display("FAIL abort_pre_ir: got %h expected 3", jif.IR_OUT); end
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    TRST = 1'b1;
    step(1'b0, 1'b1);
    TRST = 1'b0;
    total++; if (jif.TLR !== 1'b1 || jif.TDO_EN !== 1'b0) begin bad++; $display("FAIL abort_tlr: got tlr=%b en=%b expected 1/0", jif.TLR, jif.TDO_EN); end
    go_rti();
    total++; if (jif.IR_OUT !== 4'h1) begin bad++; $display("FAIL abort_ir: got %h expected 1", jif.IR_OUT); end
  endtask

  task automatic test_idcode();
    logic [63:0] t, d;
    int unsigned e, n;
    pulse_trst();
    go_rti();
    scan(1'b0, 32, 64'd0, t, e);
    total++; if (t[31:0] !== IDC) begin bad++; $display("FAIL idcode_value: got %h expected %h", t[31:0], IDC); end
    total++; if (e != 0) begin bad++; $display("FAIL idcode_en: got %0d errors expected 0", e); end
    total++; if (jif.IR_OUT !== 4'h1) begin bad++; $display("FAIL idcode_ir: got %h expected 1", jif.IR_OUT); end
    n = $urandom_range(33, 64);
    d = {$urandom(), $urandom()};
    scan(1'b0, n, d, t, e);
    total++; if ((t & mask_n(n)) !== dr_out(1, n, d, '0)) begin bad++; $display("FAIL idcode_passthru: got %h expected %h", t & mask_n(n), dr_out(1, n, d, '0)); end
  endtask

  task automatic test_tlr_by_tms();
    go_rti();
    load_ir(4'h3);
    total++; if (jif.IR_OUT !== 4'h3) begin bad++; $display("FAIL tms_pre_ir: got %h expected 3", jif.IR_OUT); end
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    total++; if (jif.SHIFTDR !== 1'b1) begin bad++; $display("FAIL tms_in_shdr: got %b expected 1", jif.SHIFTDR); end
    repeat (5) step(1'b1, 1'b0);
    total++; if (jif.TLR !== 1'b1 || jif.IR_OUT !== 4'h1) begin bad++; $display("FAIL tms_tlr: got tlr=%b ir=%h expected 1/1", jif.TLR, jif.IR_OUT); end
    for (int t = 0; t < 16; t++) begin
      go_rti();
      load_ir(IR_W'($urandom()));
      repeat ($urandom_range(0, 12)) step(1'($urandom()), 1'($urandom()));
      repeat (5) step(1'b1, 1'b0);
      total++; if (jif.TLR !== 1'b1 || jif.IR_OUT !== 4'h1) begin bad++; $display("FAIL tms_walk_%0d: got tlr=%b ir=%h expected 1/1", t, jif.TLR, jif.IR_OUT); end
      step(1'b0, 1'b0);
      total++; if (jif.TLR !== 1'b0 || jif.IR_OUT !== 4'h1) begin bad++; $display("FAIL tms_walk_rti_%0d: got tlr=%b ir=%h expected 0/1", t, jif.TLR, jif.IR_OUT); end
    end
  endtask

  task automatic test_bypass();
    logic [63:0] t;
    int unsigned e;
    logic [IR_W-1:0] codes [2];
    codes[0] = 4'hF;
    codes[1] = 4'h7;
    go_rti();
    for (int i = 0; i < 2; i++) begin
      load_ir(codes[i]);
      total++; if (jif.IR_OUT !== codes[i] || jif.UDR_SEL !== 2'b00) begin bad++; $display("FAIL bypass_ir_%0d: got ir=%h sel=%b expected %h/00", i, jif.IR_OUT, jif.UDR_SEL, codes[i]); end
      scan(1'b0, 4, 64'b1101, t, e);
      total++; if (t[3:0] !== 4'b1010 || e != 0) begin bad++; $display("FAIL bypass_tdo_%0d: got %b en_err=%0d expected 1010/0", i, t[3:0], e); end
    end
  endtask

  task automatic test_user();
    logic [NUM_UDR-1:0] u;
    go_rti();
    load_ir(4'h3);
    total++; if (jif.UDR_SEL !== 2'b10) begin bad++; $display("FAIL user_sel: got %b expected 10", jif.UDR_SEL); end
    step(1'b1, 1'b0);
    total++; if (jif.CAPTUREDR !== 1'b0) begin bad++; $display("FAIL user_seldr_cap: got %b expected 0", jif.CAPTUREDR); end
    step(1'b0, 1'b0);
    total++; if (jif.CAPTUREDR !== 1'b1 || jif.SHIFTDR !== 1'b0) begin bad++; $display("FAIL user_capture: got cap=%b sh=%b expected 1/0", jif.CAPTUREDR, jif.SHIFTDR); end
    for (int i = 0; i < 8; i++) begin
      u = NUM_UDR'($urandom());
      jif.UDR_TDO = u;
      step(1'b0, 1'($urandom()));
      total++; if (jif.SHIFTDR !== 1'b1 || jif.CAPTUREDR !== 1'b0 || jif.TDO !== u[1]) begin bad++; $display("FAIL user_shift_%0d: got sh=%b cap=%b tdo=%b expected 1/0/%b", i, jif.SHIFTDR, jif.CAPTUREDR, jif.TDO, u[1]); end
    end
    step(1'b1, 1'b0);
    total++; if (jif.SHIFTDR !== 1'b0 || jif.TDO_EN !== 1'b0) begin bad++; $display("FAIL user_exit: got sh=%b en=%b expected 0/0", jif.SHIFTDR, jif.TDO_EN); end
    step(1'b1, 1'b0);
    total++; if (jif.UPDATEDR !== 1'b1) begin bad++; $display("FAIL user_update: got %b expected 1", jif.UPDATEDR); end
    step(1'b0, 1'b0);
    total++; if (jif.UPDATEDR !== 1'b0) begin bad++; $display("FAIL user_rti: got %b expected 0", jif.UPDATEDR); end
    load_ir(4'h1);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    total++; if (jif.CAPTUREDR !== 1'b0) begin bad++; $display("FAIL user_unqualified_cap: got %b expected 0", jif.CAPTUREDR); end
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    total++; if (jif.UPDATEDR !== 1'b0) begin bad++; $display("FAIL user_unqualified_upd: got %b expected 0", jif.UPDATEDR); end
    step(1'b0, 1'b0);
  endtask

  task automatic test_ir_pause();
    logic [3:0] o, p, r;
    go_rti();
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    o[0] = jif.TDO; step(1'b0, 1'b0);
    o[1] = jif.TDO; step(1'b0, 1'b1);
    o[2] = jif.TDO; step(1'b0, 1'b0);
    o[3] = jif.TDO; step(1'b1, 1'b1);
    total++; if (o !== 4'b0001) begin bad++; $display("FAIL irpause_capture: got %b expected 0001 (LSB first 1,0,0,0)", o); end
    step(1'b0, 1'b1);
    total++; if (jif.TDO_EN !== 1'b0 || jif.TDO !== 1'b0) begin bad++; $display("FAIL irpause_en: got en=%b tdo=%b expected 0/0", jif.TDO_EN, jif.TDO); end
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    step(1'b1, 1'b1); step(1'b0, 1'b0);
    total++; if (jif.TDO_EN !== 1'b1) begin bad++; $display("FAIL irpause_resume_en: got %b expected 1", jif.TDO_EN); end
    r = 4'($urandom());
    p[0] = jif.TDO; step(1'b0, r[0]);
    p[1] = jif.TDO; step(1'b0, r[1]);
    p[2] = jif.TDO; step(1'b0, r[2]);
    p[3] = jif.TDO; step(1'b1, r[3]);
    total++; if (p !== 4'b1010) begin bad++; $display("FAIL irpause_hold: got %b expected 1010", p); end
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    total++; if (jif.IR_OUT !== r) begin bad++; $display("FAIL irpause_update: got %h expected %h", jif.IR_OUT, r); end
  endtask

  task automatic test_back_to_back();
    logic [IR_W-1:0]    code;
    logic [NUM_UDR-1:0] u;
    logic [63:0]        t, d;
    int unsigned        e, n;
    go_rti();
    for (int i = 0; i < 24; i++) begin
      code = IR_W'($urandom());
      scan(1'b1, IR_W, 64'(code), t, e);
      total++; if (t[IR_W-1:0] !== 4'b0001 || e != 0) begin bad++; $display("FAIL b2b_ircap_%0d: got %b en_err=%0d expected 0001/0", i, t[IR_W-1:0], e); end
      total++; if (jif.IR_OUT !== code || jif.UDR_SEL !== sel_of(code)) begin bad++; $display("FAIL b2b_decode_%0d: got ir=%h sel=%b expected %h/%b", i, jif.IR_OUT, jif.UDR_SEL, code, sel_of(code)); end
      u = NUM_UDR'($urandom());
      jif.UDR_TDO = u;
      n = $urandom_range(1, 64);
      d = {$urandom(), $urandom()};
      scan(1'b0, n, d, t, e);
      total++; if ((t & mask_n(n)) !== dr_out(kind_of(code), n, d, u) || e != 0) begin bad++; $display("FAIL b2b_dr_%0d: ir=%h n=%0d got %h en_err=%0d expected %h/0", i, code, n, t & mask_n(n), e, dr_out(kind_of(code), n, d, u)); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish by 5000000 expected finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    jif.TMS     = 1'b1;
    jif.TDI     = 1'b0;
    jif.UDR_TDO = '0;
    test_reset();
    test_trst_abort();
    test_idcode();
    test_tlr_by_tms();
    test_bypass();
    test_user();
    test_ir_pause();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
